pipeline_ctrl: RTL
==================

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 The block SHALL have these parameters, one per line as name, default, meaning:
  - TIMEOUT, 15, maximum number of MEM_WAIT cycles before the block declares a fault (range 1..15).
REQ-002 The block SHALL have these ports, one per line as name, direction, width, meaning:
  - clk  input  1  sole clock; all state updates on its rising edge.
  - rst  input  1  asynchronous, active-high reset.
  - id_regsrc1_i  input  4  ID-stage source register 1; 4'b1111 means no register source.
  - id_regsrc2_i  input  4  ID-stage source register 2; 4'b1111 means no register source.
  - ex_memread_i  input  1  the EX-stage instruction is a load.
  - ex_regdst_i  input  4  EX-stage destination register; 4'b1111 means none.
  - branch_taken_i  input  1  a branch or jump resolved taken this cycle.
  - mem_req_i  input  1  the MEM stage requests the shared SRAM for a data access.
  - mem_done_i  input  1  the SRAM data access completes this cycle.
  - stall_pc_o  output  1  hold the PC.
  - stall_ifid_o  output  1  hold the IF/ID register.
  - stall_idex_o  output  1  hold the ID/EX register.
  - stall_exmem_o  output  1  hold the EX/MEM register.
  - flush_ifid_o  output  1  load a NOP into IF/ID.
  - flush_idex_o  output  1  load a NOP into ID/EX (bubble).
  - sram_sel_o  output  1  SRAM owner: 0 = IF, 1 = MEM.
  - err_o  output  1  sticky memory-timeout fault.
  - stall_cnt_o  output  16  count of cycles in which stall_pc_o was 1.

Function
REQ-003 The block SHALL implement a registered FSM with states RUN, MEM_WAIT and FAULT.
REQ-004 The load-use term SHALL be lu = ex_memread_i & (ex_regdst_i != 4'b1111) & (ex_regdst_i == id_regsrc1_i | ex_regdst_i == id_regsrc2_i).
REQ-005 A source equal to 4'b1111 SHALL never match ex_regdst_i.
REQ-006 All outputs except err_o and stall_cnt_o SHALL be combinational functions of the state and the current inputs; there SHALL be zero cycles of latency.
REQ-007 In RUN, events SHALL be prioritised mem_req_i > branch_taken_i > lu, and only the highest-priority active event SHALL act.
REQ-008 In RUN with mem_req_i=1:
  - sram_sel_o=1 and stall_pc_o=stall_ifid_o=stall_idex_o=1;
  - stall_exmem_o = ~mem_done_i;
  - next state is RUN if mem_done_i=1, otherwise MEM_WAIT.
REQ-009 In RUN with branch_taken_i=1 (and mem_req_i=0), flush_ifid_o=flush_idex_o=1, there SHALL be no stalls, and the FSM SHALL stay in RUN.
REQ-010 In RUN with lu=1 only, stall_pc_o=stall_ifid_o=1 and flush_idex_o=1 (a one-bubble insertion), and the FSM SHALL stay in RUN.
REQ-011 In RUN with no event, all stall, flush and sram_sel outputs SHALL be 0.
REQ-012 In MEM_WAIT:
  - sram_sel_o=1 and stall_pc_o=stall_ifid_o=stall_idex_o=1;
  - stall_exmem_o = ~mem_done_i;
  - flush outputs are 0, and branch_taken_i and lu are ignored.
REQ-013 A 4-bit wait counter SHALL clear on entry to MEM_WAIT and increment each MEM_WAIT cycle without mem_done_i.
REQ-014 In MEM_WAIT, mem_done_i=1 SHALL cause RUN next cycle, with precedence over timeout in the same cycle.
REQ-015 When the wait counter equals TIMEOUT and mem_done_i=0, the next state SHALL be FAULT.
REQ-016 In FAULT:
  - all four stall outputs are 1, flush outputs are 0, and sram_sel_o=0;
  - err_o=1 from the first FAULT cycle;
  - the FSM leaves FAULT only on reset.
REQ-017 stall_cnt_o SHALL increment by 1 at each clock edge where stall_pc_o=1 and SHALL saturate at 16'hFFFF.

Reset
REQ-018 While rst=1, the FSM SHALL be in RUN and the wait counter, err_o and stall_cnt_o SHALL be 0.
REQ-019 While rst=1, all stall and flush outputs and sram_sel_o SHALL be forced to 0 regardless of the inputs.
REQ-020 Reset asserted mid-MEM_WAIT or in FAULT SHALL return the FSM to RUN asynchronously, with no residual stall.

Verification
REQ-021 Load-use: ex_memread_i=1, ex_regdst_i=4'h3, id_regsrc2_i=4'h3 -> in that cycle stall_pc_o=stall_ifid_o=flush_idex_o=1; stall_cnt_o rises by 1.
REQ-022 No-source match: ex_memread_i=1, ex_regdst_i=4'hF, id_regsrc1_i=4'hF -> no stall and no flush.
REQ-023 Simultaneous mem_req_i, branch_taken_i and lu -> only the mem stalls are asserted (flush outputs 0) and the state is MEM_WAIT next cycle.
REQ-024 mem_req_i followed by mem_done_i three cycles later -> 4 cycles with sram_sel_o=1, stall_exmem_o=0 in the done cycle, RUN afterwards, and stall_cnt_o=4.
REQ-025 mem_req_i held with mem_done_i never asserted (TIMEOUT=15) -> FAULT and err_o=1 after 16 stall cycles; mem_done_i afterwards has no effect; rst then clears everything.
REQ-026 rst pulsed mid-MEM_WAIT -> all outputs 0 immediately and stall_cnt_o=0.

Source files
------------

// File: rtl/pipeline_ctrl.sv
// Pipeline hazard/stall controller: load-use bubbles, branch flushes and
// arbitration of the shared SRAM between IF and MEM with a wait timeout.
module pipeline_ctrl #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  id_regsrc1_i,
  input  logic [3:0]  id_regsrc2_i,
  input  logic        ex_memread_i,
  input  logic [3:0]  ex_regdst_i,
  input  logic        branch_taken_i,
  input  logic        mem_req_i,
  input  logic        mem_done_i,
  output logic        stall_pc_o,
  output logic        stall_ifid_o,
  output logic        stall_idex_o,
  output logic        stall_exmem_o,
  output logic        flush_ifid_o,
  output logic        flush_idex_o,
  output logic        sram_sel_o,
  output logic        err_o,
  output logic [15:0] stall_cnt_o
);

  localparam logic [3:0] NO_REG = 4'hF;
  localparam logic [3:0] TMO    = 4'(TIMEOUT);

  typedef enum logic [1:0] {RUN, MEM_WAIT, FAULT} state_e;

  state_e      state_q, state_d;
  logic [3:0]  wait_cnt_q, wait_cnt_d;
  logic        err_q, err_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic        lu;

  // NO_REG on the destination can never match, so a 4'hF source never matches either.
  assign lu = ex_memread_i & (ex_regdst_i != NO_REG) &
              ((ex_regdst_i == id_regsrc1_i) | (ex_regdst_i == id_regsrc2_i));

  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    stall_pc_o    = 1'b0;
    stall_ifid_o  = 1'b0;
    stall_idex_o  = 1'b0;
    stall_exmem_o = 1'b0;
    flush_ifid_o  = 1'b0;
    flush_idex_o  = 1'b0;
    sram_sel_o    = 1'b0;
    case (state_q)
      RUN: begin
        if (mem_req_i) begin
          sram_sel_o    = 1'b1;
          stall_pc_o    = 1'b1;
          stall_ifid_o  = 1'b1;
          stall_idex_o  = 1'b1;
          stall_exmem_o = ~mem_done_i;
          if (!mem_done_i) begin
            state_d    = MEM_WAIT;
            wait_cnt_d = 4'd0;
          end
        end else if (branch_taken_i) begin
          flush_ifid_o = 1'b1;
          flush_idex_o = 1'b1;
        end else if (lu) begin
          stall_pc_o   = 1'b1;
          stall_ifid_o = 1'b1;
          flush_idex_o = 1'b1;
        end
      end
      MEM_WAIT: begin
        sram_sel_o    = 1'b1;
        stall_pc_o    = 1'b1;
        stall_ifid_o  = 1'b1;
        stall_idex_o  = 1'b1;
        stall_exmem_o = ~mem_done_i;
        // A completing access wins over a timeout in the same cycle.
        if (mem_done_i)
          state_d = RUN;
        else if (wait_cnt_q == TMO)
          state_d = FAULT;
        else
          wait_cnt_d = wait_cnt_q + 4'd1;
      end
      FAULT: begin
        stall_pc_o    = 1'b1;
        stall_ifid_o  = 1'b1;
        stall_idex_o  = 1'b1;
        stall_exmem_o = 1'b1;
      end
      default: state_d = RUN;
    endcase
    if (rst) begin
      stall_pc_o    = 1'b0;
      stall_ifid_o  = 1'b0;
      stall_idex_o  = 1'b0;
      stall_exmem_o = 1'b0;
      flush_ifid_o  = 1'b0;
      flush_idex_o  = 1'b0;
      sram_sel_o    = 1'b0;
    end
    err_d       = err_q | (state_d == FAULT);
    stall_cnt_d = (stall_pc_o && stall_cnt_q != 16'hFFFF) ? stall_cnt_q + 16'd1 : stall_cnt_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= RUN;
      wait_cnt_q  <= 4'd0;
      err_q       <= 1'b0;
      stall_cnt_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      err_q       <= err_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign err_o       = err_q;
  assign stall_cnt_o = stall_cnt_q;

endmodule
